// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - branch target buffer with 2-bit saturating direction counters
//
// Purpose: predicts a next-PC redirect for the IF-stage fetch address and is
// trained by resolved branches/jumps from ID.
// Optional feature: define BP_BYPASS_EN to forward a same-index update to the
// lookup outputs in the same cycle.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   pc_i           lookup fetch address
//   hit_o          valid entry with matching tag
//   pred_taken_o   redirect fetch (hit & ctr[1])
//   pred_target_o  stored target, zero on miss
//   upd_valid_i    resolved control-transfer present in ID
//   upd_pc_i       address of resolved instruction
//   upd_taken_i    resolved direction
//   upd_target_i   resolved target
//   flush_all_i    invalidate every entry (wins over a concurrent update)
//   mispredict_o   registered: previous update disagreed with stored prediction
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              flush_all_i,
  output logic              mispredict_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic               mispredict_q, mispredict_d;
  // Low for the first edge after reset release so that edge cannot train.
  logic               rst_done_q;

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic             u_hit, u_pred, u_we;
  logic             u_valid_d;
  logic [TAG_W-1:0] u_tag_d;
  logic [ADDR_W-1:0] u_tgt_d;
  logic [1:0]       u_ctr_d;

  logic             e_valid;
  logic [TAG_W-1:0] e_tag;
  logic [ADDR_W-1:0] e_tgt;
  logic [1:0]       e_ctr;

  // Word-alignment bits play no part in indexing or tagging.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
  assign u_idx  = upd_pc_i[IDX_W+1:2];
  assign u_tag  = upd_pc_i[ADDR_W-1:IDX_W+2];

  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_pred = u_hit && ctr_q[u_idx][1];

  always_comb begin
    mispredict_d = 1'b0;
    if (upd_valid_i && rst_done_q) begin
      mispredict_d = (u_pred != upd_taken_i) ||
                     (u_pred && upd_taken_i && (tgt_q[u_idx] != upd_target_i));
    end
  end

  // Post-update contents of the addressed entry; u_we says whether it changes.
  always_comb begin
    u_we      = 1'b0;
    u_valid_d = valid_q[u_idx];
    u_tag_d   = tag_q[u_idx];
    u_tgt_d   = tgt_q[u_idx];
    u_ctr_d   = ctr_q[u_idx];
    if (upd_valid_i && !flush_all_i && rst_done_q) begin
      if (u_hit) begin
        u_we = 1'b1;
        if (upd_taken_i) begin
          u_tgt_d = upd_target_i;
          if (ctr_q[u_idx] != 2'b11) u_ctr_d = ctr_q[u_idx] + 2'd1;
        end else if (ctr_q[u_idx] != 2'b00) begin
          u_ctr_d = ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        u_we      = 1'b1;
        u_valid_d = 1'b1;
        u_tag_d   = u_tag;
        u_tgt_d   = upd_target_i;
        u_ctr_d   = 2'b10;
      end
    end
  end

`ifdef BP_BYPASS_EN
  logic byp;
  assign byp     = u_we && (u_idx == lk_idx);
  assign e_valid = byp ? u_valid_d : valid_q[lk_idx];
  assign e_tag   = byp ? u_tag_d   : tag_q[lk_idx];
  assign e_tgt   = byp ? u_tgt_d   : tgt_q[lk_idx];
  assign e_ctr   = byp ? u_ctr_d   : ctr_q[lk_idx];
`else
  assign e_valid = valid_q[lk_idx];
  assign e_tag   = tag_q[lk_idx];
  assign e_tgt   = tgt_q[lk_idx];
  assign e_ctr   = ctr_q[lk_idx];
`endif

  assign hit_o         = e_valid && (e_tag == lk_tag);
  assign pred_taken_o  = hit_o && e_ctr[1];
  assign pred_target_o = hit_o ? e_tgt : '0;
  assign mispredict_o  = mispredict_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q      <= '0;
      mispredict_q <= 1'b0;
      rst_done_q   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else begin
      rst_done_q   <= 1'b1;
      mispredict_q <= mispredict_d;
      if (flush_all_i) begin
        valid_q <= '0;
      end else if (u_we) begin
        valid_q[u_idx] <= u_valid_d;
        tag_q[u_idx]   <= u_tag_d;
        tgt_q[u_idx]   <= u_tgt_d;
        ctr_q[u_idx]   <= u_ctr_d;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        flush_all_i;
  logic        mispredict_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];

  branch_predictor #(.ADDR_W(32), .ENTRIES(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .hit_o        (hit_o),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(pred_target_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i),
    .flush_all_i  (flush_all_i),
    .mispredict_o (mispredict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s scoreboard empty observed=%0h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic eh, input logic et, input logic [31:0] etgt);
    exp_q.push_back({31'b0, eh});
    exp_q.push_back({31'b0, et});
    exp_q.push_back(etgt);
    pc_i = pc;
    #1;
    chk({tag, ".hit"}, {31'b0, hit_o});
    chk({tag, ".taken"}, {31'b0, pred_taken_o});
    chk({tag, ".target"}, pred_target_o);
  endtask

  task automatic step(input string tag, input logic exp_mp);
    exp_q.push_back({31'b0, exp_mp});
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    flush_all_i = 1'b0;
    chk({tag, ".mispredict"}, {31'b0, mispredict_o});
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = tk;
    upd_target_i = tgt;
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic exp_mp);
    set_upd(pc, tk, tgt);
    step(tag, exp_mp);
  endtask

  initial begin
    // Reset asserted while an update is being presented.
    rst_i = 1'b0;
    pc_i = 32'h40;
    flush_all_i = 1'b0;
    set_upd(32'h40, 1'b1, 32'h100);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    look("rst_hold", 32'h40, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h0);
    chk("rst_hold.mispredict", {31'b0, mispredict_o});
    upd_valid_i = 1'b0;
    rst_i = 1'b1;
    step("rst_first", 1'b0);
    look("rst_look", 32'h40, 1'b0, 1'b0, 32'h0);

    // Allocate and train down.
    upd("alloc", 32'h40, 1'b1, 32'h100, 1'b1);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    upd("nt1", 32'h40, 1'b0, 32'h0, 1'b1);
    look("nt1", 32'h40, 1'b1, 1'b0, 32'h100);
    upd("nt2", 32'h40, 1'b0, 32'h0, 1'b0);
    look("nt2", 32'h40, 1'b1, 1'b0, 32'h100);

    // Saturate up at 11, then one not-taken leaves it weakly taken.
    upd("sat1", 32'h40, 1'b1, 32'h100, 1'b1);
    upd("sat2", 32'h40, 1'b1, 32'h100, 1'b1);
    upd("sat3", 32'h40, 1'b1, 32'h100, 1'b0);
    upd("sat4", 32'h40, 1'b1, 32'h100, 1'b0);
    look("sat", 32'h40, 1'b1, 1'b1, 32'h100);
    upd("sat_nt", 32'h40, 1'b0, 32'h0, 1'b1);
    look("sat_nt", 32'h40, 1'b1, 1'b1, 32'h100);

    // Correct direction but wrong target counts as a mispredict.
    upd("tgt_chg", 32'h40, 1'b1, 32'h104, 1'b1);
    look("tgt_chg", 32'h40, 1'b1, 1'b1, 32'h104);

    // Aliasing: 0x80 evicts 0x40 at index 0.
    upd("alias", 32'h80, 1'b1, 32'h200, 1'b1);
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);

    // Miss + not taken leaves the entry alone; low address bits ignored.
    upd("miss_nt", 32'hC0, 1'b0, 32'h0, 1'b0);
    look("miss_nt", 32'h80, 1'b1, 1'b1, 32'h200);
    look("low_bits", 32'h83, 1'b1, 1'b1, 32'h200);

    // Same-cycle lookup and allocation of the same index.
    set_upd(32'h40, 1'b1, 32'h300);
`ifdef BP_BYPASS_EN
    look("conflict_now", 32'h40, 1'b1, 1'b1, 32'h300);
`else
    look("conflict_now", 32'h40, 1'b0, 1'b0, 32'h0);
`endif
    step("conflict", 1'b1);
    look("conflict_next", 32'h40, 1'b1, 1'b1, 32'h300);
    look("conflict_evict", 32'h80, 1'b0, 1'b0, 32'h0);

    // Flush wins over a concurrent update; mispredict still reported.
    set_upd(32'h60, 1'b1, 32'h400);
    flush_all_i = 1'b1;
    step("flush", 1'b1);
    look("flush_40", 32'h40, 1'b0, 1'b0, 32'h0);
    look("flush_60", 32'h60, 1'b0, 1'b0, 32'h0);

    // Re-allocate after flush, then reset asynchronously mid-update.
    upd("realloc", 32'h40, 1'b1, 32'h500, 1'b1);
    look("realloc", 32'h40, 1'b1, 1'b1, 32'h500);
    set_upd(32'h40, 1'b0, 32'h0);
    rst_i = 1'b0;
    look("async_rst", 32'h40, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h0);
    chk("async_rst.mispredict", {31'b0, mispredict_o});
    upd_valid_i = 1'b0;
    #3;
    rst_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
